// File: rtl/cube_net_driver.sv
// cube_net_driver: host-side initiator for the cube solver network.
// Collects WORDS state words from the host, pulses net_load, streams the
// words on net_d, then waits (bounded by TIMEOUT) for the network's move code
// and hands it back to the host over a valid/ready handshake.
module cube_net_driver #(
  parameter int DATA_W  = 120,
  parameter int WORDS   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              net_load,
  output logic [DATA_W-1:0] net_d,
  input  logic              net_valid,
  input  logic [3:0]        net_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_move,
  output logic              out_timeout,
  output logic              busy
);

  localparam int              IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [15:0]     TO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IDX_W-1:0]    r_idx;
  logic [15:0]         r_cnt;
  logic [DATA_W-1:0]   r_word [WORDS];
  logic [3:0]          r_move;
  logic                r_timeout;
  logic                w_in_hs;

  assign out_move    = r_move;
  assign out_timeout = r_timeout;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and state-driven outputs; net_d is zero outside STREAM.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    net_load  = 1'b0;
    net_d     = '0;
    out_valid = 1'b0;
    busy      = 1'b1;
    w_in_hs   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        w_in_hs  = in_valid;
        if (in_valid && (r_idx == LAST_IDX)) w_next = S_LOAD;
      end
      S_LOAD: begin
        net_load = 1'b1;
        w_next   = S_STREAM;
      end
      S_STREAM: begin
        net_d = r_word[r_idx];
        if (r_idx == LAST_IDX) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (net_valid || (r_cnt == TO_LAST)) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Word index: counts host handshakes in IDLE, then walks the stream; wraps to 0 after the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_in_hs || (r_state == S_STREAM)) begin
      r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end
  end

  // Cube-state buffer, written only on host handshakes and kept after use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) r_word[i] <= '0;
    end else if (w_in_hs) begin
      r_word[r_idx] <= in_data;
    end
  end

  // Wait counter: cleared while streaming so WAIT always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_STREAM) begin
      r_cnt <= '0;
    end else if ((r_state == S_WAIT) && !net_valid && (r_cnt != TO_LAST)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Result capture: a network result beats a timeout landing on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_move    <= 4'h0;
      r_timeout <= 1'b0;
    end else if (r_state == S_WAIT) begin
      if (net_valid) begin
        r_move    <= net_q;
        r_timeout <= 1'b0;
      end else if (r_cnt == TO_LAST) begin
        r_move    <= 4'hF;
        r_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cube_net_driver.sv
// Directed testbench for cube_net_driver (WORDS=4, TIMEOUT=16).
module tb_cube_net_driver;

  localparam int DW = 120;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          net_load;
  logic [DW-1:0] net_d;
  logic          net_valid;
  logic [3:0]    net_q;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_move;
  logic          out_timeout;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  cube_net_driver #(.DATA_W(DW), .WORDS(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .net_load(net_load), .net_d(net_d),
    .net_valid(net_valid), .net_q(net_q),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_move(out_move), .out_timeout(out_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; observe 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive four words back-to-back; returns with the DUT in LOAD.
  task automatic load_words(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] c, input logic [DW-1:0] d);
    logic [DW-1:0] w [4];
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; net_valid = 1'b0; net_q = 4'h0; out_ready = 1'b0;
    #3;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_cmp++; if (net_load !== 1'b0) begin n_bad++; $display("FAIL reset_net_load got %b exp 0", net_load); end
    n_cmp++; if (net_d !== '0) begin n_bad++; $display("FAIL reset_net_d got %h exp 0", net_d); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_move !== 4'h0) begin n_bad++; $display("FAIL reset_out_move got %h exp 0", out_move); end
    n_cmp++; if (out_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_out_timeout got %b exp 0", out_timeout); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_w;
    load_words(120'h1, 120'h2, 120'h3, 120'h4);
    n_cmp++; if (net_load !== 1'b1) begin n_bad++; $display("FAIL basic_load got %b exp 1", net_load); end
    n_cmp++; if (net_d !== '0) begin n_bad++; $display("FAIL basic_load_d got %h exp 0", net_d); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_load_in_ready got %b exp 0", in_ready); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_load_busy got %b exp 1", busy); end
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_w = DW'(k + 1);
      n_cmp++; if (net_load !== 1'b0) begin n_bad++; $display("FAIL basic_stream_load k=%0d got %b exp 0", k, net_load); end
      n_cmp++; if (net_d !== exp_w) begin n_bad++; $display("FAIL basic_stream_d k=%0d got %h exp %h", k, net_d, exp_w); end
    end
    tick();
    n_cmp++; if (net_d !== '0) begin n_bad++; $display("FAIL basic_wait_d got %h exp 0", net_d); end
    for (int c = 1; c < 10; c++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_wait_valid c=%0d got %b exp 0", c, out_valid); end
    end
    net_valid = 1'b1; net_q = 4'h7;
    tick();
    net_valid = 1'b0; net_q = 4'h0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_done_valid got %b exp 1", out_valid); end
    n_cmp++; if (out_move !== 4'h7) begin n_bad++; $display("FAIL basic_done_move got %h exp 7", out_move); end
    n_cmp++; if (out_timeout !== 1'b0) begin n_bad++; $display("FAIL basic_done_timeout got %b exp 0", out_timeout); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_ack_valid got %b exp 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ack_in_ready got %b exp 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_ack_busy got %b exp 0", busy); end
    n_cmp++; if (out_move !== 4'h7) begin n_bad++; $display("FAIL basic_ack_move_kept got %h exp 7", out_move); end
  endtask

  task automatic test_gapped_backpressure();
    logic [DW-1:0] w [4];
    w[0] = 120'hA0A0; w[1] = 120'hB1B1; w[2] = 120'hC2C2; w[3] = 120'hD3D3;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[i];
      tick();
      if (i < 3) begin
        in_valid = 1'b0; in_data = 120'hDEAD;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL gap_in_ready i=%0d got %b exp 1", i, in_ready); end
      end
    end
    in_valid = 1'b0; in_data = '0;
    n_cmp++; if (net_load !== 1'b1) begin n_bad++; $display("FAIL gap_load got %b exp 1", net_load); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (net_d !== w[k]) begin n_bad++; $display("FAIL gap_stream_d k=%0d got %h exp %h", k, net_d, w[k]); end
    end
    tick();
    net_valid = 1'b1; net_q = 4'h3;
    tick();
    net_q = 4'h5;
    for (int c = 0; c < 20; c++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid c=%0d got %b exp 1", c, out_valid); end
      n_cmp++; if (out_move !== 4'h3) begin n_bad++; $display("FAIL bp_move c=%0d got %h exp 3", c, out_move); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready c=%0d got %b exp 0", c, in_ready); end
      tick();
    end
    net_valid = 1'b0; net_q = 4'h0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready got %b exp 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_timeout();
    load_words(120'h11, 120'h22, 120'h33, 120'h44);
    for (int k = 0; k < 5; k++) tick();
    for (int c = 1; c < 16; c++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL to_wait_valid c=%0d got %b exp 0", c, out_valid); end
    end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL to_done_valid got %b exp 1", out_valid); end
    n_cmp++; if (out_move !== 4'hF) begin n_bad++; $display("FAIL to_done_move got %h exp f", out_move); end
    n_cmp++; if (out_timeout !== 1'b1) begin n_bad++; $display("FAIL to_done_timeout got %b exp 1", out_timeout); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_timeout !== 1'b1) begin n_bad++; $display("FAIL to_ack_timeout_kept got %b exp 1", out_timeout); end
  endtask

  task automatic test_timeout_race();
    load_words(120'h5, 120'h6, 120'h7, 120'h8);
    for (int k = 0; k < 5; k++) tick();
    for (int c = 1; c < 16; c++) tick();
    net_valid = 1'b1; net_q = 4'hA;
    tick();
    net_valid = 1'b0; net_q = 4'h0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL race_to_valid got %b exp 1", out_valid); end
    n_cmp++; if (out_move !== 4'hA) begin n_bad++; $display("FAIL race_to_move got %h exp a", out_move); end
    n_cmp++; if (out_timeout !== 1'b0) begin n_bad++; $display("FAIL race_to_timeout got %b exp 0", out_timeout); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_stream_race();
    load_words(120'h9, 120'hA, 120'hB, 120'hC);
    tick();
    net_valid = 1'b1; net_q = 4'h9;
    tick();
    net_valid = 1'b0; net_q = 4'h0;
    tick(); tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL srace_wait_valid c=%0d got %b exp 0", c, out_valid); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL srace_wait_busy c=%0d got %b exp 1", c, busy); end
    end
    net_valid = 1'b1; net_q = 4'h2;
    tick();
    net_valid = 1'b0; net_q = 4'h0;
    n_cmp++; if (out_move !== 4'h2) begin n_bad++; $display("FAIL srace_move got %h exp 2", out_move); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL srace_valid got %b exp 1", out_valid); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w [4];
    load_words(120'h111, 120'h222, 120'h333, 120'h444);
    tick(); tick();
    n_cmp++; if (net_d !== 120'h222) begin n_bad++; $display("FAIL rmid_pre_d got %h exp 222", net_d); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (net_d !== '0) begin n_bad++; $display("FAIL rmid_net_d got %h exp 0", net_d); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ready got %b exp 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b exp 0", busy); end
    n_cmp++; if (out_move !== 4'h0) begin n_bad++; $display("FAIL rmid_move got %h exp 0", out_move); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
    #1;
    rst_n = 1'b1;
    tick();
    w[0] = 120'h55; w[1] = 120'h66; w[2] = 120'h77; w[3] = 120'h88;
    load_words(w[0], w[1], w[2], w[3]);
    n_cmp++; if (net_load !== 1'b1) begin n_bad++; $display("FAIL rmid_fresh_load got %b exp 1", net_load); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (net_d !== w[k]) begin n_bad++; $display("FAIL rmid_fresh_d k=%0d got %h exp %h", k, net_d, w[k]); end
    end
    tick();
    net_valid = 1'b1; net_q = 4'h1;
    tick();
    net_valid = 1'b0; net_q = 4'h0;
    n_cmp++; if (out_move !== 4'h1) begin n_bad++; $display("FAIL rmid_fresh_move got %h exp 1", out_move); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped_backpressure();
    test_timeout();
    test_timeout_race();
    test_stream_race();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
